serial_subtractor: RTL

//  Bit-serial unsigned subtractor: computes diff = a - b over WIDTH cycles, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_cells.sv | 39 +++
 rtl/serial_subtractor.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cells.sv
// Combinational subtractor cells: a half subtractor and a full subtractor built from two of them.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b;
  assign bout = ~a & b;
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .diff (w_d1),
    .bout (w_b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs1 (
    .a    (w_d1),
    .b    (bin),
    .diff (diff),
    .bout (w_b2)
  );

  assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused for WIDTH cycles, LSB first,
// framed by a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borrow_out;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bo)
  );

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign w_res_next = {w_d, r_res_sr};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_res_sr     <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res_sr <= w_res_next[WIDTH-1:1];
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          // Outputs only ever see the completed result.
          if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule
